decoder: RTL and testbench
==========================

// Module: decoder
// PURPOSE
//  Binary-to-one-hot decoder: SEL_W-bit select drives exactly one of 2**SEL_W outputs high.
//  Primary output `out` is purely combinational, with zero latency.
//  It must be correct with clk/rst_n unconnected or idle.
//  A registered side path (out_q, changed, hit count) lets clocked consumers sample the
//  decode synchronously and monitor select activity.
// PARAMETERS
//  SEL_W   2    select width; OUT_W = 2**SEL_W derived localparam (default 4)
//  CNT_W   8    width of the change-event counter
// PORTS
//  clk      in   1        system clock, rising edge
//  rst_n    in   1        asynchronous active-low reset
//  sel      in   SEL_W    binary select
//  en       in   1        enable for the registered path only
//  out      out  OUT_W    combinational one-hot decode of sel
//  out_q    out  OUT_W    registered copy of out
//  changed  out  1        one-cycle pulse when the registered decode changes value
//  chg_cnt  out  CNT_W    saturating count of changed pulses
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rst_n).
//  - out = 1 << sel, pure combinational. Independent of clk, rst_n and en.
//    Examples: sel=00->0001, 01->0010, 10->0100, 11->1000.
//  - out always has exactly one bit set for any known sel.
//  - rst_n low (async, any time) sets out_q=0, changed=0, chg_cnt=0.
//  - While rst_n is low, out still tracks sel.
//  - At each posedge clk with rst_n high and en=1:
//    - out_q <= out (one-cycle latency).
//    - changed <= (out != out_q).
//    - chg_cnt increments when (out != out_q) and saturates at all-ones.
//  - At each posedge clk with en=0: out_q and chg_cnt hold; changed <= 0.
//  - First enabled edge after reset: out_q goes from 0 to one-hot, so changed=1 and chg_cnt=1.
//  - If sel toggles away and back between enabled edges, no change is seen (sampled compare only).
//  - Reset deassertion is not synchronised internally; the integrating level provides the synchroniser.
// STRUCTURE
//  - Package decoder_pkg: localparam SEL_W_DEF=2, CNT_W_DEF=8, and
//    function onehot(sel) returning 1<<sel.
//  - Single module. No sub-module is needed.
//  - The combinational core is one always_comb block or continuous assign using onehot().
//  - Registered path is one always_ff @(posedge clk or negedge rst_n).
// TESTING
//  - No clock, rst_n high, sel 00/01/10/11 with 10ns each:
//    out=0001/0010/0100/1000; any mismatch is an error.
//  - rst_n=0 with sel=10: out=0100 while out_q=0, changed=0, chg_cnt=0.
//  - Release reset, en=1, sel=01 held 3 clocks:
//    out_q=0010 after 1 edge; changed pulses once; chg_cnt=1.
//  - en=0, sel stepped 00->11 over 4 clocks:
//    out follows immediately; out_q, chg_cnt frozen; changed=0.
//  - en=1, sel changes every clock for 300 clocks: chg_cnt saturates at 255.
//  - Assert rst_n mid-run between edges: registered outputs clear immediately; out unaffected.
//  - SEL_W=3 build: sweep all 8 sel values; out is one-hot and equals 1<<sel.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared defaults and the one-hot helper for the select decoder.
package decoder_pkg;

    localparam int unsigned SEL_W_DEF = 2;
    localparam int unsigned CNT_W_DEF = 8;

    // Wide enough for any select up to 8 bits; callers truncate to their own width.
    function automatic logic [255:0] onehot(input logic [7:0] sel);
        return 256'(1) << sel;
    endfunction

endpackage

// File: rtl/decoder.sv
// Binary-to-one-hot decoder with a combinational output and a registered
// side path that tracks decode changes with a saturating event counter.
module decoder
    import decoder_pkg::*;
#(
    parameter  int unsigned SEL_W = SEL_W_DEF,
    parameter  int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             changed,
    output logic [CNT_W-1:0] chg_cnt
);

    logic diff;

    always_comb begin
        out  = OUT_W'(onehot(8'(sel)));
        diff = (out != out_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            changed <= 1'b0;
            chg_cnt <= '0;
        end else if (en) begin
            out_q   <= out;
            changed <= diff;
            if (diff && (chg_cnt != '1)) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: default 2-bit build plus a 3-bit build for the sweep.
module tb_decoder;

    logic       clk     = 1'b0;
    logic       run_clk = 1'b0;
    logic       rst_n   = 1'b1;
    logic [1:0] sel;
    logic [2:0] sel3;
    logic       en;

    logic [3:0] out;
    logic [3:0] out_q;
    logic       changed;
    logic [7:0] chg_cnt;

    logic [7:0] out3;
    logic [7:0] out3_q;
    logic       changed3;
    logic [7:0] chg_cnt3;

    decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .en      (en),
        .out     (out),
        .out_q   (out_q),
        .changed (changed),
        .chg_cnt (chg_cnt)
    );

    decoder #(.SEL_W(3), .CNT_W(8)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel3),
        .en      (1'b0),
        .out     (out3),
        .out_q   (out3_q),
        .changed (changed3),
        .chg_cnt (chg_cnt3)
    );

    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];

    // Reference model state for the registered path.
    logic [3:0] m_q;
    logic       m_chg;
    logic [7:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_oh(input int s);
        logic [31:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            0:       return 32'(out);
            1:       return 32'(out_q);
            2:       return 32'(changed);
            3:       return 32'(chg_cnt);
            default: return 32'(out3);
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] val);
        sb.push_back('{tag, sig, val});
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic push_regs(input string pfx);
        push({pfx, "_out_q"}, 1, 32'(m_q));
        push({pfx, "_changed"}, 2, 32'(m_chg));
        push({pfx, "_cnt"}, 3, 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_q   = '0;
        m_chg = 1'b0;
        m_cnt = '0;
    endtask

    task automatic set_sel(input logic [1:0] v);
        sel = v;
        push("out", 0, ref_oh(int'(v)));
        #1;
        drain();
    endtask

    task automatic tick(input string pfx);
        logic [3:0] nxt;
        @(posedge clk);
        if (en) begin
            nxt   = 4'(ref_oh(int'(sel)));
            m_chg = (nxt != m_q);
            if (m_chg && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            m_q   = nxt;
        end else begin
            m_chg = 1'b0;
        end
        push_regs(pfx);
        push({pfx, "_out"}, 0, ref_oh(int'(sel)));
        #1;
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        en   = 1'b0;
        sel  = '0;
        sel3 = '0;
        model_reset();

        // Unclocked decode with reset released.
        for (int i = 0; i < 4; i++) begin
            set_sel(2'(i));
            #9;
        end

        for (int i = 0; i < 8; i++) begin
            sel3 = 3'(i);
            push("out3", 4, ref_oh(i));
            #1;
            drain();
            check("out3_onehot", 32'($countones(out3)), 32'd1);
        end

        // Reset asserted: registered path clear, out still tracks sel.
        rst_n = 1'b0;
        model_reset();
        push_regs("rst");
        set_sel(2'b10);

        // Release between edges, hold sel=01 for three enabled edges.
        run_clk = 1'b1;
        en      = 1'b1;
        set_sel(2'b01);
        #3;
        rst_n = 1'b1;
        repeat (3) tick("hold");
        check("hold_cnt_one", 32'(chg_cnt), 32'd1);

        // Disabled: registered state frozen while out follows sel.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_sel(2'(i));
            tick("frz");
        end

        // Toggle away and back between edges is invisible to the sampled compare.
        en = 1'b1;
        set_sel(2'b11);
        tick("tg_a");
        set_sel(2'b00);
        set_sel(2'b11);
        tick("tg_b");

        // Continuous change drives the counter into saturation.
        repeat (300) begin
            set_sel(2'(sel + 2'd1));
            tick("sat");
        end
        check("sat_cnt_max", 32'(chg_cnt), 32'd255);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        model_reset();
        push_regs("arst");
        push("arst_out", 0, ref_oh(int'(sel)));
        #1;
        drain();

        #2;
        rst_n = 1'b1;
        set_sel(2'b10);
        tick("post");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
